x_demux: RTL and testbench

80 MHz-to-40 MHz demultiplexer and phase aligner. Receives a WIDTH-bit bus carrying two time slices per 40 MHz period, produces the (1st, 2nd) slice pair once per two 80 MHz clocks, and finds the correct slice ordering by hunting for a training pair. It is the receive end of the double-rate link whose transmitter sends slice 1st then slice 2nd on successive clock2x edges.

---
 rtl/x_demux_pkg.sv | 34 +++
 rtl/x_demux_align.sv | 150 +++++++++++++++
 rtl/x_demux.sv | 90 +++++++++
 tb/tb_x_demux.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_demux_pkg.sv
// Shared types and constants for the x_demux double-rate receive demultiplexer.
// Optional build macro X_DEMUX_SLIPCNT_EN is consumed by x_demux and x_demux_align.
package x_demux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } align_state_e;

    localparam logic [7:0] DEF_TRAIN_1ST = 8'hA5;
    localparam logic [7:0] DEF_TRAIN_2ND = 8'h5A;

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned GOOD_W  = 4;
    localparam int unsigned SLIP_W  = 8;

    localparam logic [TIMER_W-1:0] TIMER_ONE = 8'd1;
    localparam logic [GOOD_W-1:0]  GOOD_ONE  = 4'd1;
    localparam logic [SLIP_W-1:0]  SLIP_ONE  = 8'd1;

    // Saturating increment used by the slip counter.
    function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v);
        logic [SLIP_W-1:0] r;
        if (v == {SLIP_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + SLIP_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/x_demux_align.sv
// Alignment controller for x_demux: hunts for the training pair, confirms it
// on LOCK_COUNT slots and owns sel_phase. Slip counter under X_DEMUX_SLIPCNT_EN.
module x_demux_align
    import x_demux_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TRAIN_1ST  = WIDTH'(DEF_TRAIN_1ST),
    parameter logic [WIDTH-1:0] TRAIN_2ND  = WIDTH'(DEF_TRAIN_2ND),
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      HUNT_MAX   = 64
) (
    input  logic             clock2x,
    input  logic             reset_n,
    input  logic             tgl,
    input  logic             align_req,
    input  logic [WIDTH-1:0] pair_1st,
    input  logic [WIDTH-1:0] pair_2nd,
    output logic             sel_phase,
    output logic             locked,
    output logic             lock_err
`ifdef X_DEMUX_SLIPCNT_EN
    ,
    output logic [SLIP_W-1:0] slip_cnt
`endif
);

    align_state_e       state_r, state_s;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic [GOOD_W-1:0]  good_r, good_s;
    logic               sel_r, sel_s;
    logic               err_r, err_s;
    logic               locked_r;
    logic               req_d_r;
    logic               rise_s;
    logic               match_s;
    logic               slot_s;
`ifdef X_DEMUX_SLIPCNT_EN
    logic [SLIP_W-1:0]  slip_r, slip_s;
`endif

    assign rise_s  = align_req & ~req_d_r;
    assign match_s = (pair_1st == TRAIN_1ST) && (pair_2nd == TRAIN_2ND);
    assign slot_s  = (tgl == sel_r);

    // Next-state logic: a new request always wins, then per-state hunting/confirming.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        good_s  = good_r;
        sel_s   = sel_r;
        err_s   = err_r;
`ifdef X_DEMUX_SLIPCNT_EN
        slip_s  = slip_r;
`endif
        if (rise_s) begin
            state_s = HUNT;
            timer_s = '0;
            good_s  = '0;
            err_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                HUNT: begin
                    if (match_s) begin
`ifdef X_DEMUX_SLIPCNT_EN
                        if (tgl != sel_r) begin
                            slip_s = sat_inc(slip_r);
                        end else begin
                            slip_s = slip_r;
                        end
`endif
                        sel_s   = tgl;
                        good_s  = GOOD_ONE;
                        timer_s = '0;
                        state_s = CONFIRM;
                    end else if (timer_r == TIMER_W'(HUNT_MAX - 1)) begin
                        state_s = IDLE;
                        timer_s = '0;
                        err_s   = 1'b1;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                CONFIRM: begin
                    if (slot_s && match_s) begin
                        good_s = good_r + GOOD_ONE;
                        if ((good_r + GOOD_ONE) == GOOD_W'(LOCK_COUNT)) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = CONFIRM;
                        end
                    end else if (slot_s) begin
                        state_s = HUNT;
                        good_s  = '0;
                        timer_s = '0;
                    end else begin
                        state_s = CONFIRM;
                    end
                end
                LOCKED: begin
                    state_s = LOCKED;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clock2x or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            timer_r  <= '0;
            good_r   <= '0;
            sel_r    <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
            req_d_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            good_r   <= good_s;
            sel_r    <= sel_s;
            err_r    <= err_s;
            locked_r <= (state_s == LOCKED);
            req_d_r  <= align_req;
        end
    end

`ifdef X_DEMUX_SLIPCNT_EN
    // Slip counter survives realignment; only reset clears it.
    always_ff @(posedge clock2x or negedge reset_n) begin
        if (!reset_n) begin
            slip_r <= '0;
        end else begin
            slip_r <= slip_s;
        end
    end

    assign slip_cnt = slip_r;
`endif

    assign sel_phase = sel_r;
    assign locked    = locked_r;
    assign lock_err  = err_r;

endmodule

// File: rtl/x_demux.sv
// 80-to-40 MHz demultiplexer: pairs successive beats and emits them on the
// slot chosen by x_demux_align. Optional slip_cnt port under X_DEMUX_SLIPCNT_EN.
module x_demux
    import x_demux_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TRAIN_1ST  = WIDTH'(DEF_TRAIN_1ST),
    parameter logic [WIDTH-1:0] TRAIN_2ND  = WIDTH'(DEF_TRAIN_2ND),
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      HUNT_MAX   = 64
) (
    input  logic             clock2x,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             align_req,
    output logic [WIDTH-1:0] dout1st,
    output logic [WIDTH-1:0] dout2nd,
    output logic             dout_vld,
    output logic             phase,
    output logic             locked,
    output logic             lock_err
`ifdef X_DEMUX_SLIPCNT_EN
    ,
    output logic [7:0]       slip_cnt
`endif
);

    logic [WIDTH-1:0] din_ff_r;
    logic [WIDTH-1:0] din_prev_r;
    logic [WIDTH-1:0] dout1st_r;
    logic [WIDTH-1:0] dout2nd_r;
    logic             dout_vld_r;
    logic             tgl_r;
    logic             sel_phase_s;
    logic             slot_s;

    x_demux_align #(
        .WIDTH      (WIDTH),
        .TRAIN_1ST  (TRAIN_1ST),
        .TRAIN_2ND  (TRAIN_2ND),
        .LOCK_COUNT (LOCK_COUNT),
        .HUNT_MAX   (HUNT_MAX)
    ) u_align (
        .clock2x   (clock2x),
        .reset_n   (reset_n),
        .tgl       (tgl_r),
        .align_req (align_req),
        .pair_1st  (din_prev_r),
        .pair_2nd  (din_ff_r),
        .sel_phase (sel_phase_s),
        .locked    (locked),
        .lock_err  (lock_err)
`ifdef X_DEMUX_SLIPCNT_EN
        ,
        .slip_cnt  (slip_cnt)
`endif
    );

    assign slot_s = (tgl_r == sel_phase_s);

    // Beat capture, slot toggle and pair output registers.
    always_ff @(posedge clock2x or negedge reset_n) begin
        if (!reset_n) begin
            din_ff_r   <= '0;
            din_prev_r <= '0;
            tgl_r      <= 1'b0;
            dout1st_r  <= '0;
            dout2nd_r  <= '0;
            dout_vld_r <= 1'b0;
        end else begin
            din_ff_r   <= din;
            din_prev_r <= din_ff_r;
            tgl_r      <= ~tgl_r;
            dout_vld_r <= slot_s;
            if (slot_s) begin
                dout1st_r <= din_prev_r;
                dout2nd_r <= din_ff_r;
            end else begin
                dout1st_r <= dout1st_r;
                dout2nd_r <= dout2nd_r;
            end
        end
    end

    assign dout1st  = dout1st_r;
    assign dout2nd  = dout2nd_r;
    assign dout_vld = dout_vld_r;
    assign phase    = sel_phase_s;

endmodule

// File: tb/tb_x_demux.sv
// Scoreboard bench for x_demux: a beat-history reference model predicts pairs
// and alignment status; a negedge monitor compares what the DUT presents.
module tb_x_demux;

    localparam int         LOCKN = 4;
    localparam int         HMAX  = 64;
    localparam logic [7:0] T1    = 8'hA5;
    localparam logic [7:0] T2    = 8'h5A;

    logic       clock2x = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       align_req = 1'b0;
    logic [7:0] dout1st, dout2nd;
    logic       dout_vld, phase, locked, lock_err;
`ifdef X_DEMUX_SLIPCNT_EN
    logic [7:0] slip_cnt;
`endif

    x_demux #(.WIDTH(8), .TRAIN_1ST(T1), .TRAIN_2ND(T2), .LOCK_COUNT(LOCKN), .HUNT_MAX(HMAX)) dut (
        .clock2x   (clock2x),
        .reset_n   (reset_n),
        .din       (din),
        .align_req (align_req),
        .dout1st   (dout1st),
        .dout2nd   (dout2nd),
        .dout_vld  (dout_vld),
        .phase     (phase),
        .locked    (locked),
        .lock_err  (lock_err)
`ifdef X_DEMUX_SLIPCNT_EN
        ,
        .slip_cnt  (slip_cnt)
`endif
    );

    always #5 clock2x = ~clock2x;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
    } pair_t;

    pair_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    cur_req = 1'b0;

    // Reference model: beat history plus alignment status in plain terms.
    int         m_k;
    logic [7:0] m_b1, m_b2;
    bit         m_req_prev, m_sel, m_err;
    int         m_mode;  // 0 idle, 1 hunting, 2 confirming, 3 locked
    int         m_good, m_timer, m_slip;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_b1 = 8'h00; m_b2 = 8'h00; m_req_prev = 1'b0;
        m_sel = 1'b0; m_err = 1'b0; m_mode = 0; m_good = 0; m_timer = 0; m_slip = 0;
        sb_q.delete();
    endtask

    task automatic model_edge(input logic [7:0] d, input bit r);
        bit    tg, rise, match, slot;
        pair_t p;
        tg    = m_k[0];
        rise  = r && !m_req_prev;
        match = (m_b2 == T1) && (m_b1 == T2);
        slot  = (tg == m_sel);
        p.d1  = m_b2;
        p.d2  = m_b1;
        if (rise) begin
            m_mode = 1; m_timer = 0; m_good = 0; m_err = 1'b0;
        end else if (m_mode == 1) begin
            if (match) begin
                if (tg != m_sel && m_slip < 255) m_slip++;
                m_sel = tg; m_good = 1; m_mode = 2;
            end else if (m_timer + 1 == HMAX) begin
                m_mode = 0; m_err = 1'b1; m_timer = 0;
            end else begin
                m_timer++;
            end
        end else if (m_mode == 2 && slot) begin
            if (match) begin
                m_good++;
                if (m_good == LOCKN) m_mode = 3;
            end else begin
                m_mode = 1; m_good = 0; m_timer = 0;
            end
        end
        if (slot) sb_q.push_back(p);
        m_b2 = m_b1; m_b1 = d; m_req_prev = r; m_k++;
    endtask

    // Monitor: pops expected pairs on dout_vld and checks status every cycle.
    always @(negedge clock2x) begin
        pair_t e;
        if (reset_n) begin
            if (dout_vld) begin
                if (sb_q.size() == 0) begin
                    check("vld_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("dout1st", dout1st, e.d1);
                    check("dout2nd", dout2nd, e.d2);
                end
            end else if (sb_q.size() != 0) begin
                check("vld_missing", 0, 1);
                void'(sb_q.pop_front());
            end
            check("locked", locked, (m_mode == 3) ? 1 : 0);
            check("lock_err", lock_err, m_err);
            check("phase", phase, m_sel);
`ifdef X_DEMUX_SLIPCNT_EN
            check("slip_cnt", slip_cnt, m_slip);
`endif
        end
    end

    function automatic logic [7:0] rnd_beat();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        while (v == T1 || v == T2) v = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic step(input logic [7:0] d);
        din = d;
        align_req = cur_req;
        @(posedge clock2x);
        model_edge(d, cur_req);
        #1;
    endtask

    task automatic align_to(input int par);
        if ((m_k % 2) != par) step(rnd_beat());
    endtask

    task automatic new_request();
        cur_req = 1'b0;
        step(rnd_beat());
        cur_req = 1'b1;
        step(rnd_beat());
    endtask

    task automatic train(input int n);
        for (int i = 0; i < n; i++) begin
            step(T1);
            step(T2);
        end
    endtask

    task automatic random_beats(input int n);
        for (int i = 0; i < n; i++) step(rnd_beat());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout1st"}, dout1st, 0);
        check({tag, "_dout2nd"}, dout2nd, 0);
        check({tag, "_dout_vld"}, dout_vld, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lock_err"}, lock_err, 0);
`ifdef X_DEMUX_SLIPCNT_EN
        check({tag, "_slip_cnt"}, slip_cnt, 0);
`endif
    endtask

    task automatic mid_reset();
        @(negedge clock2x);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        cur_req = 1'b0;
        align_req = 1'b0;
        din = 8'h00;
        repeat (2) @(negedge clock2x);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        check_reset_outputs("rst");
        #12;
        reset_n = 1'b1;

        // Idle with counting data: pairs (0,1),(2,3)... on even parity.
        for (int i = 0; i < 20; i++) step(8'(i));

        // Align on odd parity, held request, then data passes in order.
        new_request();
        align_to(1);
        train(5);
        random_beats(20);
        cur_req = 1'b0;
        step(rnd_beat());

        // Even parity with one corrupted pair after two matches.
        new_request();
        align_to(0);
        train(2);
        step(T1);
        step(8'h00);
        train(5);
        random_beats(16);

        // Hunt timeout, then a new request clears lock_err.
        new_request();
        random_beats(HMAX + 6);
        new_request();
        align_to(0);
        train(5);
        random_beats(6);

        // Transmitter slips a beat, retrain on the other parity.
        step(rnd_beat());
        new_request();
        align_to(1);
        train(5);
        random_beats(8);

        // Reset while confirming.
        new_request();
        align_to(0);
        train(2);
        mid_reset();
        for (int i = 0; i < 10; i++) step(8'(i + 100));

        // Randomized rounds: mixed clean/corrupt training on random parity.
        for (int r = 0; r < 8; r++) begin
            new_request();
            random_beats($urandom_range(0, 5));
            for (int j = 0; j < 7; j++) begin
                if ($urandom_range(0, 9) < 7) begin
                    step(T1);
                    step(T2);
                end else begin
                    step(T1);
                    step(rnd_beat());
                end
            end
            random_beats($urandom_range(2, 9));
        end

        cur_req = 1'b0;
        random_beats(4);
        @(negedge clock2x);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
